// File: rtl/m92_pkg.sv
// Shared definitions for the M92 sprite path: burst geometry, fetch FSM
// states and the 64-bit address alignment helper.
package m92_pkg;

  localparam int SPRITE_BURST_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2
  } sprite_rom_state_t;

  // Sprite words are 64-bit aligned; the low three byte-address bits are dropped.
  function automatic logic [24:0] align64(input logic [24:0] a);
    return {a[24:3], 3'b000};
  endfunction

endpackage

// File: rtl/sprite_rom_responder.sv
// Sprite-ROM responder: turns each newly requested 64-bit address into one
// 4-beat 16-bit SDRAM burst, assembles the word and raises rdy while the
// held word matches the address the sprite engine is asking for.
//
// Handshakes:
//   engine side : req is a level; rdy is registered and is high only while
//                 data holds the word for the aligned req_addr of the
//                 previous cycle (it drops one cycle after req/addr change).
//   sdram side  : mem_req/mem_addr are held until a one-cycle mem_ack;
//                 each mem_valid cycle carries one beat, beat0 first. A beat
//                 may coincide with mem_ack. Beats outside a burst are ignored.
module sprite_rom_responder
  import m92_pkg::*;
#(
  parameter int BEATS   = SPRITE_BURST_BEATS,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic [24:0]           req_addr,
  output logic [63:0]           data,
  output logic                  rdy,
  output logic                  mem_req,
  output logic [24:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_valid,
  input  logic [15:0]           mem_data,
  output logic                  timeout_err,
  output sprite_rom_state_t     state_dbg
);

  localparam int BW = $clog2(BEATS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

  sprite_rom_state_t           state_q, state_d;
  logic [24:0]                 cur_addr_q, cur_addr_d;
  logic [24:0]                 served_addr_q, served_addr_d;
  logic                        served_valid_q, served_valid_d;
  logic                        mem_req_q, mem_req_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [16*(BEATS-1)-1:0]     shadow_q, shadow_d;
  logic [63:0]                 data_q, data_d;
  logic                        rdy_q, rdy_d;
  logic                        terr_q, terr_d;
  logic [24:0]                 req_aligned;

  assign req_aligned = align64(req_addr);

  // Next-state logic: fetch sequencing, beat gather and timeout abort.
  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    served_addr_d  = served_addr_q;
    served_valid_d = served_valid_q;
    mem_req_d      = mem_req_q;
    beat_d         = beat_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    data_d         = data_q;
    terr_d         = terr_q;
    rdy_d          = served_valid_q && req && (served_addr_q == req_aligned);

    case (state_q)
      IDLE: begin
        if (req && (!served_valid_q || served_addr_q != req_aligned)) begin
          cur_addr_d = req_aligned;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cnt_d     = '0;
          beat_d    = '0;
          state_d   = COLLECT;
          // A beat arriving with the ack is beat0.
          if (mem_valid) begin
            shadow_d[15:0] = mem_data;
            beat_d         = BW'(1);
          end
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d      = 1'b0;
          served_valid_d = 1'b0;
          terr_d         = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COLLECT: begin
        if (mem_valid) begin
          cnt_d = '0;
          if (beat_q == LAST_BEAT) begin
            // Word lands even if the engine moved on; rdy compare filters it.
            data_d         = {mem_data, shadow_q};
            served_addr_d  = cur_addr_q;
            served_valid_d = 1'b1;
            state_d        = IDLE;
          end else begin
            for (int i = 0; i < BEATS - 1; i++) begin
              if (beat_q == BW'(i)) shadow_d[i*16 +: 16] = mem_data;
            end
            beat_d = beat_q + 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          served_valid_d = 1'b0;
          terr_d         = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any burst in flight at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cur_addr_q     <= '0;
      served_addr_q  <= '0;
      served_valid_q <= 1'b0;
      mem_req_q      <= 1'b0;
      beat_q         <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      data_q         <= '0;
      rdy_q          <= 1'b0;
      terr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      served_addr_q  <= served_addr_d;
      served_valid_q <= served_valid_d;
      mem_req_q      <= mem_req_d;
      beat_q         <= beat_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      data_q         <= data_d;
      rdy_q          <= rdy_d;
      terr_q         <= terr_d;
    end
  end

  assign data        = data_q;
  assign rdy         = rdy_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = cur_addr_q;
  assign timeout_err = terr_q;
  assign state_dbg   = state_q;

endmodule
